mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit in the Execute stage. It sits directly downstream of the operand forwarding muxes and takes the forwarded ALU operands as its inputs. While it works, it holds the pipeline through a stall request to the hazard logic. It then returns a registered 32-bit result that the Execute stage passes on to the Execute-to-Memory pipeline register.

## Interface
- XLEN, 32, operand/result width; iteration count equals XLEN.
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; forces IDLE and clears all outputs
- start  input  1  request pulse; sampled only in IDLE or DONE
- operation  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- operandA  input  XLEN  forwarded operand 1 (rs1)
- operandB  input  XLEN  forwarded operand 2 (rs2)
- flush  input  1  abort the in-flight operation (branch/exception flush)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  registered result; holds its value until the next completion
- stallRequest  output  1  to the hazard unit; combinational: (start & (IDLE|DONE)) | busy

## Operation
- States:
  - IDLE
  - CALC: counter 0..XLEN-1
  - FINISH: sign correction and result select
  - DONE
- On start, operation and operands are latched. The unit converts the operands to magnitudes according to their signedness:
  - MULH: both signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both signed.
  - All other operations: unsigned.
- Negation flags:
  - Multiply: product negation = signA_eff XOR signB_eff.
  - Divide: quotient negation = sA XOR sB.
  - Remainder negation = sA.
- Multiply uses shift-add on a 2*XLEN-bit accumulator, one bit per CALC cycle. MUL returns low XLEN bits; MULH, MULHSU and MULHU return high XLEN bits of the corrected product.
- Divide uses restoring division, one quotient bit per CALC cycle. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Fast paths skip CALC/FINISH and go IDLE→DONE directly:
  - Divisor = 0: DIV/DIVU result = all ones; REM/REMU result = operandA.
  - Signed overflow (DIV/REM, A = 0x80000000, B = 0xFFFFFFFF): DIV result = 0x80000000; REM result = 0.
- start seen while busy is ignored. start in DONE launches a new operation (back-to-back).
- flush in CALC/FINISH: next state is IDLE, no done, result is unchanged. flush in IDLE/DONE has no effect on outputs.
- Reset at any time (including mid-CALC): state = IDLE, counter = 0. busy, done, stallRequest and result all go to 0 immediately.

## Timing
- start is high in cycle 0.
- Normal path:
  - busy = 1 in cycles 1..33 (CALC cycles 1..32, FINISH cycle 33).
  - DONE is cycle 34: done = 1, busy = 0, result valid.
  - Cycle 35: IDLE unless start was sampled in cycle 34.
- Fast path: DONE in cycle 1; busy never asserts.
- stallRequest is high in cycles 0..33 on the normal path and in cycle 0 only on the fast path. It is low in the DONE cycle so the dependent instruction advances together with the result.
- result is registered on the edge that enters DONE. It holds through IDLE and is overwritten only on the next DONE.
- Latency is fixed at XLEN+2 cycles from start to done for every non-fast-path operation, regardless of operand values.

## Test plan
- MUL A=7, B=0xFFFFFFFD (−3) → result 0xFFFFFFEB. busy 1 in cycles 1..33, done in cycle 34, stallRequest low in cycle 34.
- MULHU A=B=0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU A=0xFFFFFFFF, B=2 → 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (−7), B=2 → 0xFFFFFFFD. REM → 0xFFFFFFFF. DIVU A=100, B=7 → 14. REMU → 2.
- DIV A=5, B=0 → 0xFFFFFFFF with done in cycle 1. REM A=5, B=0 → 5. DIV A=0x80000000, B=0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Back-to-back: DIVU A=100, B=7 completes with done in cycle 34; start with MUL A=3, B=4 is asserted in that same cycle 34. The MUL completes with done in cycle 68 and result 12. A start pulse in cycle 10 (while busy) is ignored.
- flush in cycle 15 of a DIV: IDLE in cycle 16, no done, result keeps its prior value. Reset asserted in cycle 20 of a MUL: all outputs 0 immediately. After release, a fresh MUL 6×7 → 42.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit -- iterative RV32M multiply/divide unit for the Execute stage.
//
// A start pulse latches funct3 and the forwarded operands, converts them to
// magnitudes, then runs XLEN shift-add (multiply) or restoring-division
// (divide) steps. A single FINISH cycle applies sign correction and selects
// the result, which is registered on the edge entering DONE. Divide-by-zero
// and signed overflow bypass the iteration and go straight to DONE.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; forces IDLE and clears outputs
//   start        request pulse, accepted only in IDLE or DONE
//   operation    funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   operandA     forwarded rs1
//   operandB     forwarded rs2
//   flush        abort an operation in CALC/FINISH
//   busy         high in CALC and FINISH
//   done         one-cycle pulse in DONE; result valid
//   result       registered result, held until the next completion
//   stallRequest (accepted start) | busy, to the hazard unit
//   debugState   current FSM state (IDLE=0, CALC=1, FINISH=2, DONE=3)
//
// Handshake: a request is taken when start is high while the unit is in IDLE
// or DONE (stallRequest rises combinationally in that cycle); the response is
// the done pulse, during which result is valid and stallRequest is low.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      operation,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stallRequest,
    output logic [1:0]      debugState
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FINISH = 2'd2, DONE = 2'd3} state_t;

    state_t            state, nextState;
    logic [CNT_W-1:0]  count;
    logic [2:0]        opReg;
    logic [XLEN-1:0]   magOp;      // multiplicand (MUL*) or divisor (DIV*)
    logic [2*XLEN-1:0] acc;        // {partial product | remainder, multiplier | quotient}
    logic              negMain;    // negate product or quotient
    logic              negRem;     // negate remainder

    // Operand decode for the request being presented
    logic            accept, isDiv, signedA, signedB, sA, sB;
    logic            divZero, overflow, fastPath;
    logic [XLEN-1:0] absA, absB, fastResult;

    always_comb begin
        accept   = start && (state == IDLE || state == DONE);
        isDiv    = operation[2];
        signedA  = (operation == 3'b001) || (operation == 3'b010) ||
                   (operation == 3'b100) || (operation == 3'b110);
        signedB  = (operation == 3'b001) || (operation == 3'b100) || (operation == 3'b110);
        sA       = signedA && operandA[XLEN-1];
        sB       = signedB && operandB[XLEN-1];
        absA     = sA ? -operandA : operandA;
        absB     = sB ? -operandB : operandB;
        divZero  = isDiv && (operandB == '0);
        overflow = ((operation == 3'b100) || (operation == 3'b110)) &&
                   (operandA == {1'b1, {(XLEN-1){1'b0}}}) && (operandB == '1);
        fastPath = divZero || overflow;
        // operation[1] separates REM/REMU from DIV/DIVU
        if (divZero) begin
            fastResult = operation[1] ? operandA : '1;
        end else begin
            fastResult = operation[1] ? '0 : operandA;
        end
    end

    // One iteration step of each algorithm
    logic [XLEN:0]     mulSum, divPartial, divDiff;
    logic [2*XLEN-1:0] mulNext, divNext;

    always_comb begin
        mulSum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, magOp} : '0);
        mulNext    = {mulSum, acc[XLEN-1:1]};
        divPartial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        divDiff    = divPartial - {1'b0, magOp};
        // Remainder stays below the divisor, so the restored value fits XLEN bits
        if (divDiff[XLEN]) begin
            divNext = {divPartial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            divNext = {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

    // Sign correction and result select in FINISH
    logic [2*XLEN-1:0] prodCorr;
    logic [XLEN-1:0]   quoCorr, remCorr, finalResult;

    always_comb begin
        prodCorr = negMain ? -acc : acc;
        quoCorr  = negMain ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        remCorr  = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (opReg[2]) begin
            finalResult = opReg[1] ? remCorr : quoCorr;
        end else begin
            finalResult = (opReg[1:0] == 2'b00) ? prodCorr[XLEN-1:0] : prodCorr[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:   if (accept) nextState = fastPath ? DONE : CALC;
            CALC: begin
                if (flush) nextState = IDLE;
                else if (count == CNT_W'(XLEN-1)) nextState = FINISH;
            end
            FINISH: nextState = flush ? IDLE : DONE;
            DONE: begin
                if (accept) nextState = fastPath ? DONE : CALC;
                else nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            opReg   <= '0;
            magOp   <= '0;
            acc     <= '0;
            negMain <= 1'b0;
            negRem  <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            count   <= '0;
            opReg   <= operation;
            magOp   <= isDiv ? absB : absA;
            acc     <= {{XLEN{1'b0}}, (isDiv ? absA : absB)};
            negMain <= sA ^ sB;
            negRem  <= sA;
            if (fastPath) result <= fastResult;
        end else if (state == CALC && !flush) begin
            count <= count + 1'b1;
            acc   <= opReg[2] ? divNext : mulNext;
        end else if (state == FINISH && !flush) begin
            result <= finalResult;
        end
    end

    always_comb begin
        busy         = (state == CALC) || (state == FINISH);
        done         = (state == DONE);
        stallRequest = !reset && (accept || busy);
        debugState   = state;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        stall_request;
  logic [1:0]  debug_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = '0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .operation(operation),
    .operandA(operand_a),
    .operandB(operand_b),
    .flush(flush),
    .busy(busy),
    .done(done),
    .result(result),
    .stallRequest(stall_request),
    .debugState(debug_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain 64-bit arithmetic on the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] t;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    case (op)
      3'd0: begin t = sa * sb; return t[31:0]; end
      3'd1: begin t = sa * sb; return t[63:32]; end
      3'd2: begin t = sa * ub; return t[63:32]; end
      3'd3: begin t = {32'b0, a} * {32'b0, b}; return t[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        t = sa / sb;
        return t[31:0];
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        t = sa % sb;
        return t[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) ||
           ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hffffffff));
  endfunction

  // monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done act=%h exp=none t=%0t", result, $time);
      end else begin
        check("result", result, exp_q.pop_front());
      end
    end
  end

  // driver: presents a request in the current cycle (cycle 0), returns in cycle 1
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input logic [31:0] exp);
    start = 1'b1;
    operation = op;
    operand_a = a;
    operand_b = b;
    if (push) begin
      exp_q.push_back(exp);
      last_exp = exp;
    end
    #1;
    check("stall_cycle0", {31'b0, stall_request}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  // follows one operation from cycle 1 to its done cycle; optional stray start
  task automatic track(input bit fast, input int ignore_at);
    int lat;
    lat = fast ? 1 : 34;
    for (int cyc = 1; cyc <= lat; cyc++) begin
      if (cyc > 1) @(negedge clk);
      check("busy", {31'b0, busy}, {31'b0, (!fast && cyc <= 33)});
      check("done", {31'b0, done}, {31'b0, (cyc == lat)});
      check("stall", {31'b0, stall_request}, {31'b0, (cyc < lat)});
      if (cyc == ignore_at) begin
        start = 1'b1;
        operation = 3'($urandom_range(0, 7));
        operand_a = $urandom;
        operand_b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[12];

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, e;
    bit          fast;
    int          sel;

    dir[0]  = '{3'd0, 32'd7, 32'hfffffffd, 32'hffffffeb};
    dir[1]  = '{3'd3, 32'hffffffff, 32'hffffffff, 32'hfffffffe};
    dir[2]  = '{3'd1, 32'hffffffff, 32'hffffffff, 32'h00000000};
    dir[3]  = '{3'd2, 32'hffffffff, 32'd2, 32'hffffffff};
    dir[4]  = '{3'd4, 32'hfffffff9, 32'd2, 32'hfffffffd};
    dir[5]  = '{3'd6, 32'hfffffff9, 32'd2, 32'hffffffff};
    dir[6]  = '{3'd5, 32'd100, 32'd7, 32'd14};
    dir[7]  = '{3'd7, 32'd100, 32'd7, 32'd2};
    dir[8]  = '{3'd4, 32'd5, 32'd0, 32'hffffffff};
    dir[9]  = '{3'd6, 32'd5, 32'd0, 32'd5};
    dir[10] = '{3'd4, 32'h80000000, 32'hffffffff, 32'h80000000};
    dir[11] = '{3'd6, 32'h80000000, 32'hffffffff, 32'd0};

    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    operation = '0;
    operand_a = '0;
    operand_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall", {31'b0, stall_request}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed vectors
    foreach (dir[i]) begin
      launch(dir[i].op, dir[i].a, dir[i].b, 1'b1, dir[i].exp);
      track(is_fast(dir[i].op, dir[i].a, dir[i].b), 0);
      @(negedge clk);
    end

    // back-to-back with an ignored start while busy
    launch(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
    track(1'b0, 10);
    launch(3'd0, 32'd3, 32'd4, 1'b1, 32'd12);
    track(1'b0, 0);
    @(negedge clk);
    check("idle_after_done", {30'b0, debug_state}, 32'd0);

    // flush mid-divide: no done, result held
    launch(3'd4, 32'd1000, 32'd3, 1'b0, '0);
    repeat (14) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_state_idle", {30'b0, debug_state}, 32'd0);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, last_exp);
    repeat (40) @(negedge clk);
    check("flush_result_held", result, last_exp);

    // reset in the middle of a multiply
    launch(3'd0, 32'd123, 32'd456, 1'b0, '0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, done}, 32'd0);
    check("mid_rst_stall", {31'b0, stall_request}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    last_exp = '0;
    @(negedge clk);
    launch(3'd0, 32'd6, 32'd7, 1'b1, 32'd42);
    track(1'b0, 0);
    @(negedge clk);

    // randomized operations against the model
    for (int i = 0; i < 50; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = '0;
        1: begin a = 32'h80000000; b = 32'hffffffff; end
        2: b = 32'hffffffff;
        3: a = 32'h80000000;
        4: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        5: begin a = -($urandom_range(1, 300)); b = $urandom_range(1, 20); end
        default: ;
      endcase
      e = model(op, a, b);
      fast = is_fast(op, a, b);
      launch(op, a, b, 1'b1, e);
      track(fast, (!fast && (i % 5 == 0)) ? $urandom_range(2, 30) : 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
